// File: rtl/ftb_update_ctrl_pkg.sv
// Shared frontend types for FTB training: entry payload, buffered update packet,
// and the update-sequencer state encoding.
package ftb_update_ctrl_pkg;

  localparam int PC_W = 32;

  typedef struct packed {
    logic        vld;
    logic [11:0] tag;
    logic [2:0]  br_type;
    logic [19:0] target;
  } ftbInfo_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    ftbInfo_t        info;
  } ftbUpdPkt_t;

  typedef logic [1:0] ftbUpdState_t;
  localparam ftbUpdState_t ST_IDLE   = 2'd0;
  localparam ftbUpdState_t ST_LOOKUP = 2'd1;
  localparam ftbUpdState_t ST_WRITE  = 2'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ftb_update_ctrl_fifo.sv
// Generic synchronous FIFO; head is read straight from registered storage.
module sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq,
  input  logic                     deq,
  input  T                         wdata,
  output T                         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (deq) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Extra pointer bit disambiguates full from empty.
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ftb_update_ctrl.sv
// Buffers committed FTB training packets and serialises them onto the FTB SRAM
// as LOOKUP/WRITE pairs, yielding to frontend lookups after MAX_BURST updates.
module ftb_update_ctrl
  import ftb_update_ctrl_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WAYS      = 4,
  parameter int MAX_BURST = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_upd_vld,
  output logic            o_upd_rdy,
  input  logic [PC_W-1:0] i_upd_pc,
  input  ftbInfo_t        i_upd_info,
  input  logic            i_lookup_req,
  output logic            o_update_req,
  output logic [PC_W-1:0] o_update_pc,
  input  logic [WAYS-1:0] i_update_sel_vec,
  output logic            o_write_req,
  output logic [WAYS-1:0] o_write_way_vec,
  output ftbInfo_t        o_write_info,
  output logic            o_idle,
  output logic [15:0]     o_drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  ftbUpdState_t  state, state_nxt;
  logic [BW-1:0] burst_cnt, burst_eff;
  ftbUpdPkt_t    head, wpkt;
  logic          full, empty, enq, deq, in_write, sel_ok, more, throttle;
  logic [AW:0]   count;

  assign wpkt      = '{pc: i_upd_pc, info: i_upd_info};
  assign enq       = i_upd_vld && !full;
  assign o_upd_rdy = !full;
  assign in_write  = (state == ST_WRITE);
  assign deq       = in_write;
  assign sel_ok    = $onehot(i_update_sel_vec);

  sync_fifo #(.DEPTH(DEPTH), .T(ftbUpdPkt_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .enq   (enq),
    .deq   (deq),
    .wdata (wpkt),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // The WRITE cycle completes an update, so its count is included when
  // deciding whether the next sequence may start immediately.
  assign burst_eff = (in_write && burst_cnt != BURST_MAX) ? burst_cnt + BW'(1) : burst_cnt;
  assign throttle  = i_lookup_req && (burst_eff >= BURST_MAX);
  // In WRITE the head is leaving, so another packet means a second entry or a fresh enqueue.
  assign more      = in_write ? ((count > (AW+1)'(1)) || enq) : (!empty || enq);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (more && !throttle) state_nxt = ST_LOOKUP;
      ST_LOOKUP: state_nxt = ST_WRITE;
      ST_WRITE:  state_nxt = (more && !throttle) ? ST_LOOKUP : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      burst_cnt  <= '0;
      o_drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) burst_cnt <= '0;
      else if (in_write)    burst_cnt <= burst_eff;
      if (in_write && !sel_ok) o_drop_cnt <= sat_inc16(o_drop_cnt);
    end
  end

  // Update request stays up through WRITE so the SRAM index is held for the write.
  assign o_update_req    = (state != ST_IDLE);
  assign o_update_pc     = o_update_req ? head.pc : '0;
  assign o_write_req     = in_write && sel_ok;
  assign o_write_way_vec = o_write_req ? i_update_sel_vec : '0;
  assign o_write_info    = o_write_req ? head.info : '0;
  assign o_idle          = empty && (state == ST_IDLE);

  ap_sel_not_multihot: assert property (@(posedge clk) disable iff (rst)
    in_write |-> $onehot0(i_update_sel_vec))
    else $error("ftb_update_ctrl: multi-hot update sel vec in WRITE");

endmodule
